// File: rtl/systolic_seq.sv
// systolic_seq
// Sequencer for an N_DIM x N_DIM output-stationary PE array. A start request
// clears the PE accumulators, streams K operand columns of A and rows of B
// out of two operand buffers, skews lane i of each edge by i cycles, keeps the
// PEs enabled until the wavefront has drained, then pulses done_o.
//
// Ports
//   clk_i       clock, rising edge
//   rst_n_i     asynchronous active-low reset
//   start_i     start request, sampled only in IDLE
//   dim_k_i     inner dimension K, captured with start_i
//   rd_en_o     operand buffer read enable
//   rd_addr_o   operand buffer read address (shared by A and B buffers)
//   a_rdata_i   A column k, lane i = A[i][k], valid one cycle after rd_en_o
//   b_rdata_i   B row k, lane j = B[k][j], valid one cycle after rd_en_o
//   a_edge_o    skewed A lanes to the column-0 PEs
//   b_edge_o    skewed B lanes to the row-0 PEs
//   pe_start_o  MAC enable to every PE
//   pe_clr_n_o  accumulator clear (low) to every PE
//   busy_o      high whenever not IDLE
//   done_o      one-cycle pulse, all accumulators final
//   err_o       one-cycle pulse after a rejected start (K = 0 or K too large)
module systolic_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int N_DIM      = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        start_i,
    input  logic [ADDR_WIDTH:0]         dim_k_i,
    output logic                        rd_en_o,
    output logic [ADDR_WIDTH-1:0]       rd_addr_o,
    input  logic [N_DIM*DATA_WIDTH-1:0] a_rdata_i,
    input  logic [N_DIM*DATA_WIDTH-1:0] b_rdata_i,
    output logic [N_DIM*DATA_WIDTH-1:0] a_edge_o,
    output logic [N_DIM*DATA_WIDTH-1:0] b_edge_o,
    output logic                        pe_start_o,
    output logic                        pe_clr_n_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int DRAIN_CYC = 2 * N_DIM - 1;
    localparam int DCNT_W    = $clog2(DRAIN_CYC + 1);
    localparam logic [DCNT_W-1:0]   DRAIN_LOAD = DCNT_W'(DRAIN_CYC - 1);
    localparam logic [ADDR_WIDTH:0] K_MAX      = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] K_ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] k_q;
    logic [ADDR_WIDTH:0] feed_cnt_q;
    logic [DCNT_W-1:0]   drain_cnt_q;
    logic                err_q;
    logic                vld_p0;

    logic k_ok;
    logic feed_last;

    assign k_ok      = (dim_k_i != '0) && (dim_k_i <= K_MAX);
    assign feed_last = (feed_cnt_q + K_ONE) == k_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, latched K and the reject flag
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            k_q         <= '0;
            feed_cnt_q  <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= (state_q == S_IDLE) && start_i && !k_ok;
            case (state_q)
                S_IDLE: begin
                    feed_cnt_q <= '0;
                    if (start_i && k_ok) begin
                        k_q <= dim_k_i;
                    end
                end
                S_FEED: begin
                    feed_cnt_q <= feed_cnt_q + K_ONE;
                    if (feed_last) begin
                        drain_cnt_q <= DRAIN_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q != '0) begin
                        drain_cnt_q <= drain_cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i && k_ok) state_d = S_CLEAR;
            S_CLEAR: state_d = S_FEED;
            S_FEED:  if (feed_last) state_d = S_DRAIN;
            S_DRAIN: if (drain_cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode directly from the state register (Moore)
    always_comb begin
        rd_en_o    = (state_q == S_FEED);
        rd_addr_o  = (state_q == S_FEED) ? feed_cnt_q[ADDR_WIDTH-1:0] : '0;
        pe_start_o = (state_q == S_FEED) || (state_q == S_DRAIN);
        pe_clr_n_o = (state_q != S_CLEAR);
        busy_o     = (state_q != S_IDLE);
        done_o     = (state_q == S_DONE);
        err_o      = err_q;
    end

    // Buffer read data is valid one cycle after rd_en_o
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_en_o;
        end
    end

    // Lane i is delayed by i register stages; invalid slots carry zero so the
    // fill and drain MACs add nothing.
    for (genvar i = 0; i < N_DIM; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_gate_p0;
        logic [DATA_WIDTH-1:0] b_gate_p0;

        assign a_gate_p0 = vld_p0 ? a_rdata_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign b_gate_p0 = vld_p0 ? b_rdata_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;

        if (i == 0) begin : g_direct
            assign a_edge_o[i*DATA_WIDTH +: DATA_WIDTH] = a_gate_p0;
            assign b_edge_o[i*DATA_WIDTH +: DATA_WIDTH] = b_gate_p0;
        end else begin : g_skew
            logic [DATA_WIDTH-1:0] a_skew_p [i];
            logic [DATA_WIDTH-1:0] b_skew_p [i];

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    for (int s = 0; s < i; s++) begin
                        a_skew_p[s] <= '0;
                        b_skew_p[s] <= '0;
                    end
                end else begin
                    a_skew_p[0] <= a_gate_p0;
                    b_skew_p[0] <= b_gate_p0;
                    for (int s = 1; s < i; s++) begin
                        a_skew_p[s] <= a_skew_p[s-1];
                        b_skew_p[s] <= b_skew_p[s-1];
                    end
                end
            end

            assign a_edge_o[i*DATA_WIDTH +: DATA_WIDTH] = a_skew_p[i-1];
            assign b_edge_o[i*DATA_WIDTH +: DATA_WIDTH] = b_skew_p[i-1];
        end
    end

endmodule

// File: tb/tb_systolic_seq.sv
// Directed testbench for systolic_seq with a behavioural operand buffer pair
// and a behavioural 4x4 output-stationary PE array on the skewed edges.
module tb_systolic_seq;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW:0]       dim_k = '0;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [N*DW-1:0]   a_rdata = '0;
    logic [N*DW-1:0]   b_rdata = '0;
    logic [N*DW-1:0]   a_edge;
    logic [N*DW-1:0]   b_edge;
    logic              pe_start;
    logic              pe_clr_n;
    logic              busy;
    logic              done;
    logic              err;

    int total = 0;
    int bad   = 0;

    systolic_seq #(.DATA_WIDTH(DW), .N_DIM(N), .ADDR_WIDTH(AW)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .dim_k_i    (dim_k),
        .rd_en_o    (rd_en),
        .rd_addr_o  (rd_addr),
        .a_rdata_i  (a_rdata),
        .b_rdata_i  (b_rdata),
        .a_edge_o   (a_edge),
        .b_edge_o   (b_edge),
        .pe_start_o (pe_start),
        .pe_clr_n_o (pe_clr_n),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    // Operand buffers: one-cycle read latency
    logic [N*DW-1:0] a_mem [16];
    logic [N*DW-1:0] b_mem [16];

    always @(posedge clk) begin
        if (rd_en) begin
            a_rdata <= a_mem[rd_addr];
            b_rdata <= b_mem[rd_addr];
        end
    end

    // Behavioural PE array: operands pass right/down one register per PE
    wire         pe_rst_n = rst_n & pe_clr_n;
    logic [DW-1:0] pa  [N][N];
    logic [DW-1:0] pb  [N][N];
    logic [31:0]   acc [N][N];

    always @(posedge clk or negedge pe_rst_n) begin
        if (!pe_rst_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    logic [DW-1:0] a_in;
                    logic [DW-1:0] b_in;
                    if (j == 0) a_in = a_edge[i*DW +: DW];
                    else        a_in = pa[i][j-1];
                    if (i == 0) b_in = b_edge[j*DW +: DW];
                    else        b_in = pb[i-1][j];
                    pa[i][j] <= a_in;
                    pb[i][j] <= b_in;
                    if (pe_start) acc[i][j] <= acc[i][j] + 32'(a_in) * 32'(b_in);
                end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Per-cycle trace of one run, index n = cycles after the start cycle t0
    logic [31:0] tr_clr   [32];
    logic [31:0] tr_rd    [32];
    logic [31:0] tr_addr  [32];
    logic [31:0] tr_pes   [32];
    logic [31:0] tr_busy  [32];
    logic [31:0] tr_done  [32];
    logic [31:0] tr_err   [32];
    logic [31:0] tr_a0    [32];
    logic [31:0] tr_a3    [32];
    logic [31:0] tr_b2    [32];
    logic [31:0] snap     [N][N];

    task automatic run(input logic [AW:0] k, input int hold, input int len);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) snap[i][j] = 32'hdead;
        start = 1'b1;
        dim_k = k;
        for (int n = 1; n <= len; n++) begin
            @(posedge clk); #1;
            if (n >= hold) start = 1'b0;
            tr_clr[n]  = 32'(pe_clr_n);
            tr_rd[n]   = 32'(rd_en);
            tr_addr[n] = 32'(rd_addr);
            tr_pes[n]  = 32'(pe_start);
            tr_busy[n] = 32'(busy);
            tr_done[n] = 32'(done);
            tr_err[n]  = 32'(err);
            tr_a0[n]   = 32'(a_edge[0*DW +: DW]);
            tr_a3[n]   = 32'(a_edge[3*DW +: DW]);
            tr_b2[n]   = 32'(b_edge[2*DW +: DW]);
            if (done)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) snap[i][j] = acc[i][j];
        end
    endtask

    // A[i][k] = 16*i + k + 1, B[k][j] = 100 + 8*k + j
    task automatic fill_pattern();
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < N; i++) begin
                a_mem[k][i*DW +: DW] = 8'(16*i + k + 1);
                b_mem[k][i*DW +: DW] = 8'(100 + 8*k + i);
            end
    endtask

    task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < N; i++) begin
                a_mem[k][i*DW +: DW] = av;
                b_mem[k][i*DW +: DW] = bv;
            end
    endtask

    task automatic check_accs(input string tag, input logic [31:0] exp);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s_acc%0d%0d", tag, i, j), snap[i][j], exp);
    endtask

    initial begin
        fill_pattern();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_err",   32'(err),      32'd0);
        check("rst_rd_en", 32'(rd_en),    32'd0);
        check("rst_addr",  32'(rd_addr),  32'd0);
        check("rst_pes",   32'(pe_start), 32'd0);
        check("rst_clr_n", 32'(pe_clr_n), 32'd1);
        check("rst_a_edge", a_edge, 32'd0);
        check("rst_b_edge", b_edge, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // K=3: full timing trace
        run(5'd3, 1, 14);
        for (int n = 1; n <= 14; n++) begin
            check($sformatf("k3_clr_n@%0d", n), tr_clr[n],  32'(n != 1));
            check($sformatf("k3_rd@%0d", n),    tr_rd[n],   32'(n >= 2 && n <= 4));
            check($sformatf("k3_addr@%0d", n),  tr_addr[n], (n >= 2 && n <= 4) ? 32'(n - 2) : 32'd0);
            check($sformatf("k3_pes@%0d", n),   tr_pes[n],  32'(n >= 2 && n <= 11));
            check($sformatf("k3_busy@%0d", n),  tr_busy[n], 32'(n >= 1 && n <= 12));
            check($sformatf("k3_done@%0d", n),  tr_done[n], 32'(n == 12));
            check($sformatf("k3_err@%0d", n),   tr_err[n],  32'd0);
        end
        check("k3_a0@2", tr_a0[2], 32'd0);
        check("k3_a0@3", tr_a0[3], 32'd1);
        check("k3_a3@5", tr_a3[5], 32'd0);
        check("k3_a3@6", tr_a3[6], 32'd49);
        check("k3_a3@7", tr_a3[7], 32'd50);
        check("k3_a3@8", tr_a3[8], 32'd51);
        check("k3_a3@9", tr_a3[9], 32'd0);
        check("k3_b2@6", tr_b2[6], 32'd110);

        // K=1
        run(5'd1, 1, 11);
        for (int n = 1; n <= 11; n++) begin
            check($sformatf("k1_rd@%0d", n),   tr_rd[n],   32'(n == 2));
            check($sformatf("k1_done@%0d", n), tr_done[n], 32'(n == 10));
            check($sformatf("k1_busy@%0d", n), tr_busy[n], 32'(n >= 1 && n <= 10));
        end

        // Rejected starts: K=0 and K=17
        run(5'd0, 1, 4);
        for (int n = 1; n <= 4; n++) begin
            check($sformatf("k0_err@%0d", n),  tr_err[n],  32'(n == 1));
            check($sformatf("k0_busy@%0d", n), tr_busy[n], 32'd0);
            check($sformatf("k0_rd@%0d", n),   tr_rd[n],   32'd0);
        end
        run(5'd17, 1, 4);
        for (int n = 1; n <= 4; n++) begin
            check($sformatf("k17_err@%0d", n),  tr_err[n],  32'(n == 1));
            check($sformatf("k17_busy@%0d", n), tr_busy[n], 32'd0);
            check($sformatf("k17_rd@%0d", n),   tr_rd[n],   32'd0);
        end

        // K=16 is the largest legal K; done at t0+25
        run(5'd16, 1, 27);
        check("k16_err@1",   tr_err[1],   32'd0);
        check("k16_rd@17",   tr_rd[17],   32'd1);
        check("k16_addr@17", tr_addr[17], 32'd15);
        check("k16_rd@18",   tr_rd[18],   32'd0);
        check("k16_done@25", tr_done[25], 32'd1);
        check("k16_busy@26", tr_busy[26], 32'd0);

        // start_i held high through a whole run: re-accepted at t0+12
        run(5'd2, 13, 25);
        for (int n = 1; n <= 25; n++) begin
            check($sformatf("hold_clr_n@%0d", n), tr_clr[n],  32'(!(n == 1 || n == 13)));
            check($sformatf("hold_err@%0d", n),   tr_err[n],  32'd0);
            check($sformatf("hold_done@%0d", n),  tr_done[n], 32'(n == 11 || n == 23));
            check($sformatf("hold_busy@%0d", n),  tr_busy[n],
                  32'((n >= 1 && n <= 11) || (n >= 13 && n <= 23)));
        end

        // Reset asserted mid-FEED
        start = 1'b1;
        dim_k = 5'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_feed_rd", 32'(rd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  32'(busy),     32'd0);
        check("mid_rst_rd",    32'(rd_en),    32'd0);
        check("mid_rst_addr",  32'(rd_addr),  32'd0);
        check("mid_rst_pes",   32'(pe_start), 32'd0);
        check("mid_rst_clr_n", 32'(pe_clr_n), 32'd1);
        check("mid_rst_done",  32'(done),     32'd0);
        check("mid_rst_a",     a_edge,        32'd0);
        check("mid_rst_b",     b_edge,        32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(5'd2, 1, 12);
        for (int n = 1; n <= 12; n++) begin
            check($sformatf("post_rd@%0d", n),   tr_rd[n],   32'(n == 2 || n == 3));
            check($sformatf("post_done@%0d", n), tr_done[n], 32'(n == 11));
        end

        // End-to-end through the PE array
        fill_const(8'd7, 8'd3);
        run(5'd2, 1, 12);
        check("e2e1_done@11", tr_done[11], 32'd1);
        check_accs("e2e1", 32'd42);
        fill_const(8'd2, 8'd1);
        run(5'd2, 1, 12);
        check("e2e2_done@11", tr_done[11], 32'd1);
        check_accs("e2e2", 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_seq.md
# systolic_seq

Sequencer for the N_DIM x N_DIM output-stationary `pe` array. On `start_i` it clears the PE accumulators and reads K operand columns of A and rows of B from two operand buffers. It skews each lane by its index onto the array's left (A) and top (B) edges, drives the PEs' `start_operation_i`, waits for the wavefront to drain, then pulses `done_o` when every `accum_o` holds the final dot product. It sits between the operand buffers and the PE array.

## Interface
- `DATA_WIDTH`, 8, operand element width.
- `N_DIM`, 4, array rows = columns = lanes per edge.
- `ADDR_WIDTH`, 4, operand buffer address width; K max = 2^ADDR_WIDTH.

- `clk_i`  in  1  clock, rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  start request; sampled only in IDLE.
- `dim_k_i`  in  ADDR_WIDTH+1  inner dimension K; captured with `start_i`.
- `rd_en_o`  out  1  buffer read enable.
- `rd_addr_o`  out  ADDR_WIDTH  read address k; shared by both buffers.
- `a_rdata_i`  in  N_DIM*DATA_WIDTH  A column k; lane i = A[i][k]. Valid 1 cycle after `rd_en_o`.
- `b_rdata_i`  in  N_DIM*DATA_WIDTH  B row k; lane j = B[k][j]. Same latency as A.
- `a_edge_o`  out  N_DIM*DATA_WIDTH  to `data_A_i` of column-0 PEs; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- `b_edge_o`  out  N_DIM*DATA_WIDTH  to `data_B_i` of row-0 PEs.
- `pe_start_o`  out  1  to every PE `start_operation_i`.
- `pe_clr_n_o`  out  1  ANDed with `rst_n_i` into the PE resets; low = clear accumulators.
- `busy_o`  out  1  high whenever state != IDLE.
- `done_o`  out  1  one-cycle pulse; all `accum_o` final.
- `err_o`  out  1  one-cycle pulse on a rejected start.

## Operation
- States: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On `start_i` with 1 <= K <= 2^ADDR_WIDTH: latch K, go to CLEAR.
  - On `start_i` with K = 0 or K > 2^ADDR_WIDTH: pulse `err_o` next cycle and stay in IDLE.
- CLEAR: 1 cycle. `pe_clr_n_o` = 0; all other outputs idle.
- FEED: K cycles.
  - `rd_en_o` = 1; `rd_addr_o` = 0, 1, ..., K-1, one per cycle.
  - `pe_start_o` = 1.
- DRAIN: 2*N_DIM-1 cycles, counted by a down-counter. `pe_start_o` = 1, `rd_en_o` = 0.
- DONE: 1 cycle. `done_o` = 1 and `pe_start_o` = 0; PEs hold `accum_o`.
- Edge skew:
  - A valid flag tracks `rd_en_o` delayed 1 cycle.
  - Lane i of each edge = that lane of `rdata` gated by the valid flag, delayed through i register stages. Lane 0 is combinational from `rdata`.
  - Lanes not carrying a valid element output 0, so fill/drain MACs add 0.
- `start_i` outside IDLE, including the DONE cycle, is ignored; no `err_o`.
- Arithmetic width is owned by the PE; the sequencer only moves operands and does no arithmetic on them.

## Timing
- Reset values (async, immediate):
  - state IDLE; `rd_en_o`, `rd_addr_o`, `pe_start_o`, `busy_o`, `done_o`, `err_o` = 0.
  - `pe_clr_n_o` = 1.
  - All skew registers 0, so `a_edge_o` = `b_edge_o` = 0.
- Let t0 be the cycle `start_i` is accepted in IDLE; all control outputs are registered.
  - t0+1: CLEAR.
  - c0 = t0+2: first FEED cycle, address 0.
  - Element k on lane i of either edge appears at cycle c0+1+k+i.
  - PE(i,j) performs its last MAC at c0+K+2*N_DIM-2.
  - `done_o` = 1 at t0+K+2*N_DIM+1.
  - IDLE at t0+K+2*N_DIM+2; `start_i` is accepted from that cycle.
- Latency start -> done = K+2*N_DIM+1 cycles. `busy_o` is high t0+1 through the DONE cycle.
- Reset mid-operation: async return to IDLE with reset values; no `done_o`. Next start behaves as from power-up.

## Test plan
- Reset asserted mid-FEED -> all outputs reach reset values in the same cycle, `pe_clr_n_o` = 1, edges 0. The next start with K=2 completes normally.
- N_DIM=4, K=3, start at t0:
  - `pe_clr_n_o` = 0 only at t0+1.
  - `rd_addr_o` = 0, 1, 2 at t0+2..t0+4.
  - A[3][0] on `a_edge_o` lane 3 at t0+6 only.
  - `done_o` at t0+12.
- K=1 -> `rd_en_o` high 1 cycle (t0+2), `done_o` at t0+10, `busy_o` high t0+1..t0+10.
- K=0, and K=17 with ADDR_WIDTH=4 -> `err_o` pulse at t0+1, `busy_o` stays 0, no reads.
- `start_i` held high through one whole run -> starts ignored while busy and in DONE, no `err_o`. A new run is accepted in the first IDLE cycle after DONE.
- End-to-end with a 4x4 `pe` array, all A = 7, all B = 3, K=2:
  - Every `accum_o` = 42 at `done_o`.
  - A second run with all A = 2, B = 1 gives every `accum_o` = 4 (accumulators cleared by CLEAR).
